// File: rtl/cmd_writer.sv
// cmd_writer: walks an inclusive memory range and emits it as a TRS-DOS /CMD
// byte stream made of load-block records followed by one transfer record.
module cmd_writer #(
    parameter int BLOCK_MAX = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] start_addr,
    input  logic [15:0] end_addr,
    input  logic [15:0] exec_addr,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_data,
    input  logic        mem_ack,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [16:0] byte_count
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        B_TYPE   = 4'd1,
        B_LEN    = 4'd2,
        B_ALO    = 4'd3,
        B_AHI    = 4'd4,
        MEM_REQ  = 4'd5,
        MEM_WAIT = 4'd6,
        B_DATA   = 4'd7,
        X_TYPE   = 4'd8,
        X_LEN    = 4'd9,
        X_LO     = 4'd10,
        X_HI     = 4'd11,
        DONE     = 4'd12
    } state_t;

    localparam logic [16:0] BLOCK_MAX_L = 17'(BLOCK_MAX);

    state_t      state_r, state_nx_s;
    logic [15:0] addr_r, addr_nx_s;
    logic [15:0] exec_r, exec_nx_s;
    logic [16:0] remain_r, remain_nx_s;
    logic [8:0]  blk_n_r, blk_n_nx_s;
    logic [8:0]  blk_left_r, blk_left_nx_s;
    logic [8:0]  blk_size_s;
    logic [8:0]  len_s;
    logic [7:0]  hold_r, hold_nx_s;
    logic [16:0] count_r, count_nx_s;
    logic        error_r, error_nx_s;
    logic        err_done_nx_s;
    logic        accept_s;
    logic        start_ok_s;
    logic        range_bad_s;

    logic [7:0]  out_data_r, out_data_nx_s;
    logic        out_valid_r, out_valid_nx_s;
    logic [15:0] mem_addr_r, mem_addr_nx_s;
    logic        mem_rd_r, mem_rd_nx_s;
    logic        busy_r, busy_nx_s;
    logic        done_r, done_nx_s;

    assign accept_s    = out_valid_r & out_ready;
    assign start_ok_s  = start & (state_r == IDLE);
    assign range_bad_s = (end_addr < start_addr);
    assign blk_size_s  = (remain_r > BLOCK_MAX_L) ? BLOCK_MAX_L[8:0] : remain_r[8:0];

    // State and datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            addr_r      <= 16'h0000;
            exec_r      <= 16'h0000;
            remain_r    <= 17'd0;
            blk_n_r     <= 9'd0;
            blk_left_r  <= 9'd0;
            hold_r      <= 8'h00;
            count_r     <= 17'd0;
            error_r     <= 1'b0;
            out_data_r  <= 8'h00;
            out_valid_r <= 1'b0;
            mem_addr_r  <= 16'h0000;
            mem_rd_r    <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            addr_r      <= addr_nx_s;
            exec_r      <= exec_nx_s;
            remain_r    <= remain_nx_s;
            blk_n_r     <= blk_n_nx_s;
            blk_left_r  <= blk_left_nx_s;
            hold_r      <= hold_nx_s;
            count_r     <= count_nx_s;
            error_r     <= error_nx_s;
            out_data_r  <= out_data_nx_s;
            out_valid_r <= out_valid_nx_s;
            mem_addr_r  <= mem_addr_nx_s;
            mem_rd_r    <= mem_rd_nx_s;
            busy_r      <= busy_nx_s;
            done_r      <= done_nx_s;
        end
    end

    // Next-state decode; emitting states only move on an accepted byte.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_ok_s && !range_bad_s) begin
                    state_nx_s = B_TYPE;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            B_TYPE:   state_nx_s = accept_s ? B_LEN   : B_TYPE;
            B_LEN:    state_nx_s = accept_s ? B_ALO   : B_LEN;
            B_ALO:    state_nx_s = accept_s ? B_AHI   : B_ALO;
            B_AHI:    state_nx_s = accept_s ? MEM_REQ : B_AHI;
            MEM_REQ:  state_nx_s = mem_ack  ? B_DATA  : MEM_WAIT;
            MEM_WAIT: state_nx_s = mem_ack  ? B_DATA  : MEM_WAIT;
            B_DATA: begin
                if (!accept_s) begin
                    state_nx_s = B_DATA;
                end else if (blk_left_r > 9'd1) begin
                    state_nx_s = MEM_REQ;
                end else if (remain_r > 17'd1) begin
                    state_nx_s = B_TYPE;
                end else begin
                    state_nx_s = X_TYPE;
                end
            end
            X_TYPE:   state_nx_s = accept_s ? X_LEN : X_TYPE;
            X_LEN:    state_nx_s = accept_s ? X_LO  : X_LEN;
            X_LO:     state_nx_s = accept_s ? X_HI  : X_LO;
            X_HI:     state_nx_s = accept_s ? DONE  : X_HI;
            DONE:     state_nx_s = IDLE;
            default:  state_nx_s = IDLE;
        endcase
    end

    // Datapath next values: job setup, block sizing, read capture, counters.
    always_comb begin
        addr_nx_s     = addr_r;
        exec_nx_s     = exec_r;
        remain_nx_s   = remain_r;
        blk_n_nx_s    = blk_n_r;
        blk_left_nx_s = blk_left_r;
        hold_nx_s     = hold_r;
        count_nx_s    = count_r;
        error_nx_s    = error_r;
        err_done_nx_s = 1'b0;
        if (start_ok_s) begin
            addr_nx_s     = start_addr;
            exec_nx_s     = exec_addr;
            remain_nx_s   = {1'b0, end_addr} - {1'b0, start_addr} + 17'd1;
            count_nx_s    = 17'd0;
            error_nx_s    = range_bad_s;
            err_done_nx_s = range_bad_s;
        end else begin
            if (accept_s) begin
                count_nx_s = count_r + 17'd1;
            end else begin
                count_nx_s = count_r;
            end
            if (state_r == B_TYPE && accept_s) begin
                blk_n_nx_s    = blk_size_s;
                blk_left_nx_s = blk_size_s;
            end else if ((state_r == MEM_REQ || state_r == MEM_WAIT) && mem_ack) begin
                hold_nx_s = mem_data;
            end else if (state_r == B_DATA && accept_s) begin
                addr_nx_s     = addr_r + 16'd1;
                remain_nx_s   = remain_r - 17'd1;
                blk_left_nx_s = blk_left_r - 9'd1;
            end else begin
                hold_nx_s = hold_r;
            end
        end
    end

    // Output decode from the upcoming state so every port is a flop.
    always_comb begin
        out_valid_nx_s = 1'b0;
        out_data_nx_s  = 8'h00;
        mem_rd_nx_s    = 1'b0;
        mem_addr_nx_s  = 16'h0000;
        len_s          = blk_n_nx_s + 9'd2;
        case (state_nx_s)
            B_TYPE:   begin out_valid_nx_s = 1'b1; out_data_nx_s = 8'h01;             end
            B_LEN:    begin out_valid_nx_s = 1'b1; out_data_nx_s = len_s[7:0];        end
            B_ALO:    begin out_valid_nx_s = 1'b1; out_data_nx_s = addr_nx_s[7:0];    end
            B_AHI:    begin out_valid_nx_s = 1'b1; out_data_nx_s = addr_nx_s[15:8];   end
            MEM_REQ,
            MEM_WAIT: begin mem_rd_nx_s = 1'b1; mem_addr_nx_s = addr_nx_s;            end
            B_DATA:   begin out_valid_nx_s = 1'b1; out_data_nx_s = hold_nx_s;         end
            X_TYPE:   begin out_valid_nx_s = 1'b1; out_data_nx_s = 8'h02;             end
            X_LEN:    begin out_valid_nx_s = 1'b1; out_data_nx_s = 8'h02;             end
            X_LO:     begin out_valid_nx_s = 1'b1; out_data_nx_s = exec_nx_s[7:0];    end
            X_HI:     begin out_valid_nx_s = 1'b1; out_data_nx_s = exec_nx_s[15:8];   end
            default:  begin out_valid_nx_s = 1'b0; out_data_nx_s = 8'h00;             end
        endcase
        busy_nx_s = (state_nx_s != IDLE) && (state_nx_s != DONE);
        done_nx_s = (state_nx_s == DONE) || err_done_nx_s;
    end

    assign out_data   = out_data_r;
    assign out_valid  = out_valid_r;
    assign mem_addr   = mem_addr_r;
    assign mem_rd     = mem_rd_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign error      = error_r;
    assign byte_count = count_r;

endmodule
